// File: rtl/fb_region_reader.sv
// ---------------------------------------------------------------------------
// fb_region_reader
// Read-back engine for the SDRAM frame buffer. On a start request it loads
// the controller read window with a linear pixel region (x, y, len), drains
// that many words from the controller read FIFO and streams the upper 24 bits
// of each word out on a valid/ready pixel port.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   sys_vaild                    SDRAM init done; starts ignored while low
//   x_pos, y_pos, len            region start column/row, pixel count
//   enable                       level start request (re-armed by going low)
//   busy                         transfer in progress
//   region_err                   1-cycle pulse: start address outside frame
//   pix_data/valid/ready/last    pixel output stream
//   fb_rd_load                   controller read-address load / FIFO clear
//   fb_rd_min_addr/max_addr      read window [min, max)
//   fb_rd                        read-FIFO pop request
//   fb_rd_data, fb_rd_empty      FIFO word (1-cycle latency), FIFO empty
// ---------------------------------------------------------------------------
module fb_region_reader #(
    parameter int H_DISP      = 1024,
    parameter int V_DISP      = 600,
    parameter int LOAD_CYCLES = 2,
    parameter int SETTLE      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_vaild,
    input  logic [15:0] x_pos,
    input  logic [15:0] y_pos,
    input  logic [23:0] len,
    input  logic        enable,
    output logic        busy,
    output logic        region_err,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        fb_rd_load,
    output logic [31:0] fb_rd_min_addr,
    output logic [31:0] fb_rd_max_addr,
    output logic        fb_rd,
    input  logic [31:0] fb_rd_data,
    input  logic        fb_rd_empty
);

    localparam logic [31:0] FB_SIZE = 32'(H_DISP * V_DISP);
    localparam int          TW      = 16;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, STREAM} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr;
    logic            done;
    logic [23:0]     eff;
    logic [23:0]     issued;
    logic [23:0]     delivered;
    logic            rd_pending;   // pop issued last cycle, word arrives now
    logic [23:0]     buf_mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;

    logic [31:0]     start_min, start_end;
    logic            start, start_err, start_zero, start_go;
    logic            buf_valid, accept, last_pix, last_accept;
    logic            room;

    // Only the pixel bits of the FIFO word are forwarded.
    logic            unused_bits;
    assign unused_bits = ^fb_rd_data[7:0];

    assign start_min  = 32'(x_pos) + 32'(y_pos) * 32'(H_DISP);
    assign start_end  = start_min + 32'(len);
    assign start      = (state == IDLE) && sys_vaild && enable && !done;
    assign start_err  = (start_min >= FB_SIZE);
    assign start_zero = (len == 24'd0);
    assign start_go   = start && !start_err && !start_zero;

    assign buf_valid   = (state == STREAM) && (count != 2'd0);
    assign accept      = buf_valid && pix_ready;
    assign last_pix    = (delivered == eff - 24'd1);
    assign last_accept = accept && last_pix;

    // Occupancy after this cycle's handshake plus the word still in flight
    // must leave a free slot, so a pop is never issued without a home.
    assign room = ({1'b0, count} - {2'b00, accept} + {2'b00, rd_pending}) < 3'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        fb_rd_load = 1'b0;
        fb_rd      = 1'b0;
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        pix_data   = buf_mem[rd_ptr];
        case (state)
            IDLE: begin
                if (start_go) state_nxt = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                fb_rd_load = 1'b1;
                if (tmr == TW'(LOAD_CYCLES - 1)) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (tmr == TW'(SETTLE - 1)) state_nxt = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                pix_valid = buf_valid;
                pix_last  = buf_valid && last_pix;
                fb_rd     = !fb_rd_empty && (issued < eff) && room;
                if (last_accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr            <= '0;
            done           <= 1'b0;
            region_err     <= 1'b0;
            fb_rd_min_addr <= '0;
            fb_rd_max_addr <= '0;
            eff            <= '0;
            issued         <= '0;
            delivered      <= '0;
            rd_pending     <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            // NOTE: the two-entry buffer is reset because it drives pix_data
            // directly; larger storage would normally be left unreset.
            buf_mem[0]     <= '0;
            buf_mem[1]     <= '0;
        end else begin
            tmr        <= (state_nxt != state) ? '0 : tmr + TW'(1);
            region_err <= start && start_err;

            if ((start && (start_err || start_zero)) || last_accept) done <= 1'b1;
            else if (!enable)                                         done <= 1'b0;

            if (start_go) begin
                fb_rd_min_addr <= start_min;
                if (start_end > FB_SIZE) begin
                    fb_rd_max_addr <= FB_SIZE;
                    eff            <= 24'(FB_SIZE - start_min);
                end else begin
                    fb_rd_max_addr <= start_end;
                    eff            <= len;
                end
                issued    <= '0;
                delivered <= '0;
                wr_ptr    <= 1'b0;
                rd_ptr    <= 1'b0;
                count     <= '0;
            end else begin
                if (fb_rd) issued <= issued + 24'd1;
                if (rd_pending) begin
                    buf_mem[wr_ptr] <= fb_rd_data[31:8];
                    wr_ptr          <= ~wr_ptr;
                end
                if (accept) begin
                    rd_ptr    <= ~rd_ptr;
                    delivered <= delivered + 24'd1;
                end
                count <= count + {1'b0, rd_pending} - {1'b0, accept};
            end
            rd_pending <= fb_rd;
        end
    end

endmodule

// File: tb/tb_fb_region_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_region_reader
// Scoreboard bench: each transfer's expected pixels are computed from the
// region arithmetic and pushed into a queue; a monitor pops and compares on
// every handshake. A small FIFO model supplies words base+i with 1-cycle
// latency. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fb_region_reader;

    localparam int H  = 1024;
    localparam int V  = 600;
    localparam int LC = 2;
    localparam int ST = 16;
    localparam int FB = H * V;

    logic        clk, rst_n, sys_vaild, enable;
    logic [15:0] x_pos, y_pos;
    logic [23:0] len;
    logic        busy, region_err, pix_valid, pix_ready, pix_last;
    logic [23:0] pix_data;
    logic        fb_rd_load, fb_rd, fb_rd_empty;
    logic [31:0] fb_rd_min_addr, fb_rd_max_addr, fb_rd_data;

    fb_region_reader #(.H_DISP(H), .V_DISP(V), .LOAD_CYCLES(LC), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild),
        .x_pos(x_pos), .y_pos(y_pos), .len(len), .enable(enable),
        .busy(busy), .region_err(region_err),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .fb_rd_load(fb_rd_load),
        .fb_rd_min_addr(fb_rd_min_addr), .fb_rd_max_addr(fb_rd_max_addr),
        .fb_rd(fb_rd), .fb_rd_data(fb_rd_data), .fb_rd_empty(fb_rd_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
    } pix_t;

    pix_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // shared between stimulus, monitor and FIFO model
    logic [31:0] word_base = 0;
    int          widx = 0;
    bit          pop_seen = 0;
    int          pops = 0;
    int          hs_count = 0;
    int          first_hs = 0, last_hs = 0;
    int          cyc = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int          empty_mode = 0; // 0 never empty, 1 random, 2 five-cycle window
    bit          stream_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor + FIFO-side sampling, on the falling edge.
    initial begin : monitor
        pix_t        e;
        bit          prev_stall  = 0;
        bit          expect_idle = 0;
        logic [23:0] prev_data   = 0;
        logic        prev_last   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall  = 0;
                expect_idle = 0;
                pop_seen    = 0;
            end else begin
                if (expect_idle) begin
                    check("idle_after_last_busy", busy, 0);
                    check("idle_after_last_valid", pix_valid, 0);
                    expect_idle = 0;
                end
                if (prev_stall) begin
                    check("stall_valid_held", pix_valid, 1);
                    check("stall_data_stable", pix_data, prev_data);
                    check("stall_last_stable", pix_last, prev_last);
                end
                if (fb_rd) check("no_pop_when_empty", fb_rd_empty, 0);
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_pixel: got %0h with no pixel expected", pix_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_data", pix_data, e.data);
                        check("pix_last", pix_last, e.last);
                        if (e.last) expect_idle = 1;
                    end
                    if (hs_count == 0) first_hs = cyc;
                    last_hs = cyc;
                    hs_count++;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
                prev_last  = pix_last;
                pop_seen   = fb_rd;
                if (fb_rd) pops++;
                if (fb_rd_load) widx = 0;
            end
        end
    end

    // Input driver + FIFO data model, 1 unit after the rising edge.
    initial begin : driver
        int scyc = 0;
        pix_ready   = 1'b1;
        fb_rd_empty = 1'b0;
        fb_rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_seen) begin
                fb_rd_data = word_base + 32'(widx);
                widx++;
            end
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ~pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (!stream_en) begin
                fb_rd_empty = 1'b0;
                scyc = 0;
            end else begin
                case (empty_mode)
                    0:       fb_rd_empty = 1'b0;
                    1:       fb_rd_empty = ($urandom_range(0, 3) == 0);
                    default: fb_rd_empty = (scyc >= 4 && scyc < 9);
                endcase
                scyc++;
            end
        end
    end

    // Start a transfer and follow it to completion against the region model.
    task automatic run_xfer(input int x, input int y, input int l, input logic [31:0] base,
                            input int rmode, input int emode, input bit b2b);
        int          mn, eff, mx, loads, waits, t;
        bit          err;
        logic [31:0] w;
        pix_t        p;
        mn  = x + y * H;
        err = (mn >= FB);
        eff = err ? 0 : ((mn + l > FB) ? FB - mn : l);
        mx  = mn + eff;

        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        x_pos      = 16'(x);
        y_pos      = 16'(y);
        len        = 24'(l);
        word_base  = base;
        rdy_mode   = rmode;
        empty_mode = emode;
        pops       = 0;
        hs_count   = 0;
        for (int i = 0; i < eff; i++) begin
            w      = base + 32'(i);
            p.data = w[31:8];
            p.last = (i == eff - 1);
            exp_q.push_back(p);
        end
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);  // first cycle after the start edge

        if (err) begin
            check("err_pulse", region_err, 1);
            check("err_busy", busy, 0);
            check("err_no_load", fb_rd_load, 0);
            @(negedge clk);
            check("err_pulse_one_cycle", region_err, 0);
            check("err_busy_after", busy, 0);
            return;
        end
        if (eff == 0) begin
            check("zero_len_busy", busy, 0);
            check("zero_len_no_load", fb_rd_load, 0);
            check("zero_len_no_err", region_err, 0);
            return;
        end

        check("start_busy", busy, 1);
        check("start_load", fb_rd_load, 1);
        check("min_addr", fb_rd_min_addr, 32'(mn));
        check("max_addr", fb_rd_max_addr, 32'(mx));

        loads = 0;
        while (fb_rd_load && loads < 100) begin
            loads++;
            @(negedge clk);
        end
        check("load_cycles", loads, LC);
        waits = 0;
        while (!fb_rd && busy && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        check("settle_cycles", waits, ST);
        check("first_pop", fb_rd, 1);
        check("min_addr_stable", fb_rd_min_addr, 32'(mn));
        stream_en = 1'b1;

        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("xfer_timeout", (t < 5000), 1);
        stream_en = 1'b0;
        check("pop_count", pops, eff);
        check("pixel_count", hs_count, eff);
        check("queue_drained", exp_q.size(), 0);
        if (b2b) check("back_to_back", last_hs - first_hs, eff - 1);

        // enable still high: no re-trigger until it drops
        repeat (4) @(negedge clk);
        check("no_retrigger_busy", busy, 0);
        check("no_retrigger_load", fb_rd_load, 0);
        exp_q.delete();
    endtask

    initial begin : stimulus
        int t;
        rst_n     = 1'b0;
        sys_vaild = 1'b0;
        enable    = 1'b0;
        x_pos     = '0;
        y_pos     = '0;
        len       = '0;

        // 1: reset held, inputs random
        repeat (5) begin
            @(posedge clk); #1;
            x_pos     = 16'($urandom);
            y_pos     = 16'($urandom);
            len       = 24'($urandom);
            enable    = 1'($urandom_range(0, 1));
            sys_vaild = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_pix_valid", pix_valid, 0);
            check("rst_fb_rd", fb_rd, 0);
            check("rst_load", fb_rd_load, 0);
            check("rst_region_err", region_err, 0);
        end
        @(posedge clk); #1;
        enable    = 1'b0;
        sys_vaild = 1'b0;
        rst_n     = 1'b1;

        // starts ignored while SDRAM init not done
        @(posedge clk); #1;
        x_pos  = 16'd3;
        y_pos  = 16'd3;
        len    = 24'd5;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("no_start_without_sys_vaild", busy, 0);
        @(posedge clk); #1;
        enable    = 1'b0;
        sys_vaild = 1'b1;

        // 2: directed short region, always ready
        run_xfer(10, 2, 4, 32'hA0B0C000, 0, 0, 1);
        // 3: ready toggling
        run_xfer(7, 1, 8, 32'h12345600, 1, 0, 0);
        // 4: FIFO empty for 5 cycles mid-stream
        run_xfer(100, 50, 16, 32'h55AA0000, 0, 2, 0);
        // 5: clipped at end of frame, then out-of-frame start
        run_xfer(1000, 599, 100, 32'h0F0F0F00, 0, 0, 1);
        run_xfer(0, 600, 10, 32'h0, 0, 0, 0);
        // zero length
        run_xfer(20, 20, 0, 32'h0, 0, 0, 0);

        // randomized regions
        for (int k = 0; k < 12; k++) begin
            int x, y, l;
            if (k % 4 == 3) begin
                x = $urandom_range(990, 1023);
                y = 599;
                l = $urandom_range(1, 60);
            end else begin
                x = $urandom_range(0, 1100);
                y = $urandom_range(0, 605);
                l = $urandom_range(0, 40);
            end
            run_xfer(x, y, l, $urandom, $urandom_range(0, 2), $urandom_range(0, 1), 0);
        end

        // 6: reset mid-stream
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        x_pos    = 16'd5;
        y_pos    = 16'd5;
        len      = 24'd30;
        rdy_mode = 0;
        empty_mode = 0;
        hs_count = 0;
        word_base = 32'hDEAD0000;
        for (int i = 0; i < 30; i++) begin
            logic [31:0] w;
            pix_t        p;
            w      = 32'hDEAD0000 + 32'(i);
            p.data = w[31:8];
            p.last = (i == 29);
            exp_q.push_back(p);
        end
        enable = 1'b1;
        t = 0;
        while (hs_count < 3 && t < 200) begin
            @(negedge clk);
            if (busy && fb_rd) stream_en = 1'b1;
            t++;
        end
        check("mid_stream_reached", (hs_count >= 3), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", pix_valid, 0);
        check("async_rst_fb_rd", fb_rd, 0);
        check("async_rst_load", fb_rd_load, 0);
        check("async_rst_data", pix_data, 0);
        check("async_rst_min", fb_rd_min_addr, 0);
        exp_q.delete();
        stream_en = 1'b0;
        enable    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_xfer(64, 10, 12, 32'h77665500, 2, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
